// File: rtl/iram_ctrl.sv
// Internal data RAM controller: byte/bit/exchange access with a hardware clear sequencer.
// Latency: 1 cycle from accept to o_valid/o_byte/o_bit/o_err; one op per cycle throughput.
// Backpressure: o_ready is low while clearing; requests seen while not ready are dropped.
module iram_ctrl #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BIT_BASE  = 'h20,
  parameter int unsigned BIT_BYTES = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_req,
  input  logic [2:0]        i_op,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wr_byte,
  input  logic              i_wr_bit,
  output logic              o_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_byte,
  output logic              o_bit,
  output logic              o_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned IW    = $clog2(DATA_W);

  localparam logic [2:0] OP_RD_BYTE = 3'd1;
  localparam logic [2:0] OP_WR_BYTE = 3'd2;
  localparam logic [2:0] OP_RD_BIT  = 3'd3;
  localparam logic [2:0] OP_WR_BIT  = 3'd4;
  localparam logic [2:0] OP_XCH     = 3'd5;

  // The bit window is never allowed to wrap past the top of the array.
  if (BIT_BASE + BIT_BYTES > DEPTH) begin : g_win_chk
    $error("iram_ctrl: bit window exceeds DEPTH");
  end
  if (DATA_W < 8 || (DATA_W & (DATA_W - 1)) != 0) begin : g_dw_chk
    $error("iram_ctrl: DATA_W must be a power of two >= 8");
  end

  typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] byte_q, byte_d;
  logic              bit_q, bit_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic                 accept;
  logic [IW-1:0]        bit_idx;
  logic [ADDR_W-IW-1:0] bit_off;
  logic [ADDR_W-1:0]    bit_waddr;
  logic                 in_win;
  logic [DATA_W-1:0]    byte_rd;
  logic [DATA_W-1:0]    bit_word;
  logic [DATA_W-1:0]    bit_word_upd;

  assign accept    = i_req & ready_q;
  assign bit_idx   = i_addr[IW-1:0];
  assign bit_off   = i_addr[ADDR_W-1:IW];
  assign bit_waddr = ADDR_W'(BIT_BASE) + ADDR_W'(bit_off);
  assign in_win    = 32'(bit_off) < BIT_BYTES;
  // Reads see the array after the previous edge's write, so no bypass is needed.
  assign byte_rd   = mem_q[i_addr];
  assign bit_word  = mem_q[bit_waddr];

  // Bit write merges the new bit into the current word contents.
  always_comb begin
    bit_word_upd          = bit_word;
    bit_word_upd[bit_idx] = i_wr_bit;
  end

  // Next-state, output and memory-write decode for clear walk and request handling.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ready_d   = ready_q;
    valid_d   = accept;
    byte_d    = byte_q;
    bit_d     = bit_q;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = i_addr;
    mem_wdata = i_wr_byte;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_idx_q;
        mem_wdata = '0;
        clr_idx_d = clr_idx_q + ADDR_W'(1);
        if (&clr_idx_q) begin
          state_d   = ST_IDLE;
          ready_d   = 1'b1;
          clr_idx_d = '0;
        end
      end
      ST_IDLE: begin
        if (accept) begin
          case (i_op)
            OP_RD_BYTE: byte_d = byte_rd;
            OP_WR_BYTE: mem_we = 1'b1;
            OP_RD_BIT: begin
              err_d = ~in_win;
              bit_d = in_win & bit_word[bit_idx];
            end
            OP_WR_BIT: begin
              err_d = ~in_win;
              if (in_win) begin
                mem_we    = 1'b1;
                mem_waddr = bit_waddr;
                mem_wdata = bit_word_upd;
              end else begin
                bit_d = 1'b0;
              end
            end
            OP_XCH: begin
              byte_d = byte_rd;
              mem_we = 1'b1;
            end
            default: ;
          endcase
        end
        // A request in the same cycle still completes; the clear starts after it.
        if (i_clr) begin
          state_d   = ST_CLEAR;
          ready_d   = 1'b0;
          clr_idx_d = '0;
        end
      end
    endcase
  end

  // Control and output registers; reset forces a restart of the clear walk.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      byte_q    <= '0;
      bit_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      byte_q    <= byte_d;
      bit_q     <= bit_d;
      err_q     <= err_d;
    end
  end

  // Storage array; contents are initialised by the clear walk, not by reset.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_byte  = byte_q;
  assign o_bit   = bit_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_iram_ctrl.sv
// Bench for iram_ctrl: directed scenarios plus random ops against a byte-array model.
module tb_iram_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       req = 1'b0;
  logic [2:0] op = 3'd0;
  logic [7:0] addr = 8'h00;
  logic [7:0] wb = 8'h00;
  logic       wbit = 1'b0;

  logic       o_ready;
  logic       o_valid;
  logic [7:0] o_byte;
  logic       o_bit;
  logic       o_err;

  int checks = 0;
  int failures = 0;

  logic [7:0] mdl_mem [256];
  logic [7:0] exp_byte = 8'h00;
  logic       exp_bit = 1'b0;

  iram_ctrl dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_clr     (clr),
    .i_req     (req),
    .i_op      (op),
    .i_addr    (addr),
    .i_wr_byte (wb),
    .i_wr_bit  (wbit),
    .o_ready   (o_ready),
    .o_valid   (o_valid),
    .o_byte    (o_byte),
    .o_bit     (o_bit),
    .o_err     (o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < 256; i++) mdl_mem[i] = 8'h00;
  endtask

  // Issue one accepted request; model computes expected outputs from the op rules.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [7:0] a,
                       input logic [7:0] d, input logic b);
    logic exp_err;
    int   off;
    int   w;
    int   bi;
    req = 1'b1; op = o; addr = a; wb = d; wbit = b;
    exp_err = 1'b0;
    off = int'(a) / 8;
    bi  = int'(a) % 8;
    w   = 32 + off;
    case (o)
      3'd1: exp_byte = mdl_mem[a];
      3'd2: mdl_mem[a] = d;
      3'd3: if (off >= 16) begin exp_err = 1'b1; exp_bit = 1'b0; end
            else exp_bit = mdl_mem[w][bi];
      3'd4: if (off >= 16) begin exp_err = 1'b1; exp_bit = 1'b0; end
            else mdl_mem[w][bi] = b;
      3'd5: begin exp_byte = mdl_mem[a]; mdl_mem[a] = d; end
      default: ;
    endcase
    @(posedge clk); #1;
    chk({tag, "_vld"}, o_valid, 1'b1);
    chk({tag, "_byte"}, o_byte, exp_byte);
    chk({tag, "_bit"}, o_bit, exp_bit);
    chk({tag, "_err"}, o_err, exp_err);
    req = 1'b0;
    clr = 1'b0;
  endtask

  task automatic idle_cycle(input string tag);
    req = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_novld"}, o_valid, 1'b0);
    chk({tag, "_hold_byte"}, o_byte, exp_byte);
    chk({tag, "_hold_bit"}, o_bit, exp_bit);
    chk({tag, "_noerr"}, o_err, 1'b0);
  endtask

  // Count edges until ready; any o_valid seen meanwhile is a dropped-request violation.
  task automatic wait_ready(input string tag);
    int cnt;
    int nv;
    cnt = 0;
    nv = 0;
    while (!o_ready && cnt < 1000) begin
      @(posedge clk); #1;
      cnt++;
      if (o_valid) nv++;
    end
    req = 1'b0;
    chk({tag, "_len"}, cnt, 256);
    chk({tag, "_novld"}, nv, 0);
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 256; i++) do_op(tag, 3'd1, 8'(i), 8'h00, 1'b0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rdy"}, o_ready, 1'b0);
    chk({tag, "_vld"}, o_valid, 1'b0);
    chk({tag, "_byte"}, o_byte, 8'h00);
    chk({tag, "_bit"}, o_bit, 1'b0);
    chk({tag, "_err"}, o_err, 1'b0);
  endtask

  initial begin
    logic [7:0] ra;
    model_zero();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("in_rst");
    rst = 1'b0;
    wait_ready("rst_clr");

    do_op("rd00", 3'd1, 8'h00, 8'h00, 1'b0);
    do_op("rd7f", 3'd1, 8'h7F, 8'h00, 1'b0);
    do_op("rdff", 3'd1, 8'hFF, 8'h00, 1'b0);

    do_op("wr30", 3'd2, 8'h30, 8'hA5, 1'b0);
    do_op("rd30", 3'd1, 8'h30, 8'h00, 1'b0);

    do_op("wr21", 3'd2, 8'h21, 8'h00, 1'b0);
    do_op("wbit0b", 3'd4, 8'h0B, 8'h00, 1'b1);
    do_op("rd21", 3'd1, 8'h21, 8'h00, 1'b0);
    do_op("rbit0b", 3'd3, 8'h0B, 8'h00, 1'b0);
    do_op("rbit0a", 3'd3, 8'h0A, 8'h00, 1'b0);

    do_op("wbit80", 3'd4, 8'h80, 8'h00, 1'b1);
    sweep("sweep_oow");

    do_op("wr40", 3'd2, 8'h40, 8'h11, 1'b0);
    do_op("xch40", 3'd5, 8'h40, 8'h22, 1'b0);
    do_op("rd40", 3'd1, 8'h40, 8'h00, 1'b0);
    idle_cycle("idle");
    do_op("nop", 3'd0, 8'h40, 8'hEE, 1'b1);
    do_op("rsv7", 3'd7, 8'h40, 8'hEE, 1'b1);

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle_cycle("rnd_idle");
      end else begin
        ra = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(32, 47)) : 8'($urandom);
        do_op("rnd", 3'($urandom_range(0, 7)), ra, 8'($urandom), 1'($urandom));
      end
    end

    clr = 1'b1;
    do_op("clr_rd", 3'd1, 8'h30, 8'h00, 1'b0);
    model_zero();
    req = 1'b1; op = 3'd1; addr = 8'h30;
    wait_ready("soft_clr");
    sweep("sweep_clr");

    do_op("wr10", 3'd2, 8'h10, 8'h5A, 1'b0);
    do_op("rd10", 3'd1, 8'h10, 8'h00, 1'b0);
    do_op("wr20", 3'd2, 8'h20, 8'hFF, 1'b0);
    do_op("rbit00", 3'd3, 8'h00, 8'h00, 1'b0);
    do_op("rd10b", 3'd1, 8'h10, 8'h00, 1'b0);
    rst = 1'b1;
    #1;
    chk_reset_outs("req_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    model_zero();
    exp_byte = 8'h00;
    exp_bit = 1'b0;
    wait_ready("req_rst_clr");

    do_op("wr10c", 3'd2, 8'h10, 8'h5A, 1'b0);
    do_op("rd10c", 3'd1, 8'h10, 8'h00, 1'b0);
    clr = 1'b1;
    req = 1'b0;
    @(posedge clk); #1;
    clr = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_outs("mid_clr_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    model_zero();
    exp_byte = 8'h00;
    exp_bit = 1'b0;
    wait_ready("mid_clr_rst_clr");
    do_op("rd10d", 3'd1, 8'h10, 8'h00, 1'b0);
    do_op("rdffd", 3'd1, 8'hFF, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
